// File: rtl/mem_access_pkg.sv
// Shared types and encodings for the load/store unit: FSM states, RV32I
// funct3 values, RAM strobe codes and request decode helpers.
package mem_access_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    RMW_MERGE = 2'd2,
    RESP      = 2'd3
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [4:0] RMEM_NONE = 5'b00000;
  localparam logic [4:0] RMEM_LB   = 5'b00001;
  localparam logic [4:0] RMEM_LH   = 5'b00010;
  localparam logic [4:0] RMEM_LW   = 5'b00100;
  localparam logic [4:0] RMEM_LBU  = 5'b01000;
  localparam logic [4:0] RMEM_LHU  = 5'b10000;

  localparam logic [3:0] WMEM_WORD = 4'b1111;

  // One-hot read strobe for a load funct3; NONE for anything not a load width.
  function automatic logic [4:0] rmem_code(input logic [2:0] funct3);
    case (funct3)
      F3_B:    return RMEM_LB;
      F3_H:    return RMEM_LH;
      F3_W:    return RMEM_LW;
      F3_BU:   return RMEM_LBU;
      F3_HU:   return RMEM_LHU;
      default: return RMEM_NONE;
    endcase
  endfunction

  // True when the request must be rejected without touching the RAM.
  function automatic logic access_error(input logic       is_load,
                                        input logic [2:0] funct3,
                                        input logic [1:0] lane);
    logic bad_funct3;
    logic misaligned;
    if (is_load)
      bad_funct3 = !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W ||
                     funct3 == F3_BU || funct3 == F3_HU);
    else
      bad_funct3 = (funct3 > F3_W);
    misaligned = ((funct3 == F3_W) && (lane != 2'b00)) ||
                 (((funct3 == F3_H) || (funct3 == F3_HU)) && lane[0]);
    return bad_funct3 || misaligned;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Little-endian lane select with sign/zero extension of a 32-bit RAM word.
// Also used with an all-ones word to produce byte/halfword lane masks.
module load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] shifted;

  // Shift the addressed lane down to bit 0, then extend to 32 bits.
  always_comb begin
    shifted = word >> {lane, 3'b000};
    case (funct3)
      F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   result = {24'h000000, shifted[7:0]};
      F3_HU:   result = {16'h0000, shifted[15:0]};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between execute and the unified word-wide block RAM.
// Loads take two cycles (RAM read is registered); sub-word stores run as a
// read-modify-write because the RAM only writes whole words.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_load,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        flush,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [3:0]  mem_wmem,
  output logic [4:0]  mem_rmem,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_store_data,
  input  logic [31:0] mem_load_data
);

  state_t                state;
  state_t                state_next;

  logic [2:0]            cap_funct3;
  logic [1:0]            cap_lane;
  logic [31:0]           cap_wdata;
  logic [ADDR_WIDTH-1:0] cap_index;

  logic                  resp_pending;
  logic [31:0]           rdata_q;
  logic                  err_q;

  logic                  accept;
  logic                  req_err;
  logic                  req_is_sw;
  logic [31:0]           load_result;
  logic [2:0]            mask_funct3;
  logic [31:0]           lane_mask;
  logic [4:0]            lane_shift;
  logic [31:0]           merged_word;
  logic                  addr_hi_unused;

  // Address bits above the RAM index wrap and are deliberately ignored.
  assign addr_hi_unused = ^req_addr[31:ADDR_WIDTH+2];

  // Reset gates acceptance so the RAM port is quiet while rst is held.
  assign accept    = (state == IDLE) && req_valid && !flush && !rst &&
                     (req_load || req_store);
  assign req_err   = access_error(req_load, req_funct3, req_addr[1:0]);
  assign req_is_sw = !req_load && (req_funct3 == F3_W);
  assign req_ready = (state == IDLE);

  load_align u_load_align (
    .word   (mem_load_data),
    .lane   (cap_lane),
    .funct3 (cap_funct3),
    .result (load_result)
  );

  // Unsigned byte/half extraction of an all-ones word yields the lane mask.
  assign mask_funct3 = (cap_funct3 == F3_B) ? F3_BU : F3_HU;

  load_align u_mask_align (
    .word   (32'hFFFF_FFFF),
    .lane   (2'b00),
    .funct3 (mask_funct3),
    .result (lane_mask)
  );

  assign lane_shift  = {cap_lane, 3'b000};
  assign merged_word = (mem_load_data & ~(lane_mask << lane_shift)) |
                       ((cap_wdata & lane_mask) << lane_shift);

  // A flush during the response cycle withdraws the completion pulse.
  assign resp_valid = resp_pending && !flush;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and the combinational RAM port.
  always_comb begin
    state_next     = state;
    mem_wmem       = 4'b0000;
    mem_rmem       = RMEM_NONE;
    mem_store_data = 32'h0000_0000;
    mem_addr       = {{(32-ADDR_WIDTH){1'b0}}, cap_index};
    case (state)
      IDLE: begin
        mem_addr = {{(32-ADDR_WIDTH){1'b0}}, req_addr[ADDR_WIDTH+1:2]};
        if (accept) begin
          if (req_err) begin
            state_next = RESP;
          end else if (req_load) begin
            mem_rmem   = rmem_code(req_funct3);
            state_next = LOAD_WAIT;
          end else if (req_is_sw) begin
            mem_wmem       = WMEM_WORD;
            mem_store_data = req_wdata;
            state_next     = RESP;
          end else begin
            mem_rmem   = RMEM_LW;
            state_next = RMW_MERGE;
          end
        end
      end
      LOAD_WAIT: begin
        state_next = flush ? IDLE : RESP;
      end
      RMW_MERGE: begin
        mem_wmem       = WMEM_WORD;
        mem_store_data = merged_word;
        state_next     = flush ? IDLE : RESP;
      end
      RESP: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Capture the accepted request for the later cycles of the operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_funct3 <= 3'b000;
      cap_lane   <= 2'b00;
      cap_wdata  <= 32'h0000_0000;
      cap_index  <= '0;
    end else if (accept) begin
      cap_funct3 <= req_funct3;
      cap_lane   <= req_addr[1:0];
      cap_wdata  <= req_wdata;
      cap_index  <= req_addr[ADDR_WIDTH+1:2];
    end
  end

  // Response registers: loaded for exactly the RESP cycle, zero otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_pending <= 1'b0;
      rdata_q      <= 32'h0000_0000;
      err_q        <= 1'b0;
    end else begin
      resp_pending <= 1'b0;
      rdata_q      <= 32'h0000_0000;
      err_q        <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && (req_err || req_is_sw)) begin
            resp_pending <= 1'b1;
            err_q        <= req_err;
          end
        end
        LOAD_WAIT: begin
          if (!flush) begin
            resp_pending <= 1'b1;
            rdata_q      <= load_result;
          end
        end
        RMW_MERGE: begin
          if (!flush) resp_pending <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a word RAM driven by the DUT port, a golden
// memory plus per-op timing model, and a per-cycle compare process.
module tb_mem_access_unit;

  localparam int AW    = 12;
  localparam int WORDS = 1 << AW;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_load, req_store, flush;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [3:0]  mem_wmem;
  logic [4:0]  mem_rmem;
  logic [31:0] mem_addr, mem_store_data, mem_load_data;

  logic [31:0] ram  [0:WORDS-1];
  logic [31:0] gold [0:WORDS-1];
  logic [31:0] rd_q;
  logic        ram_init;

  logic        chk_en;
  logic        exp_ready, exp_rvalid, exp_err;
  logic [31:0] exp_rdata, exp_sdata, exp_addr;
  logic [4:0]  exp_rmem;
  logic [3:0]  exp_wmem;
  logic [31:0] last_rdata;
  logic        last_err;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_load       (req_load),
    .req_store      (req_store),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .flush          (flush),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_wmem       (mem_wmem),
    .mem_rmem       (mem_rmem),
    .mem_addr       (mem_addr),
    .mem_store_data (mem_store_data),
    .mem_load_data  (mem_load_data)
  );

  function automatic logic [31:0] init_val(input int i);
    if (i == 16) return 32'h8899_AABB;
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  // Block RAM: whole-word write, registered read.
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < WORDS; i++) ram[i] <= init_val(i);
    end else begin
      if (mem_wmem == 4'hF) ram[mem_addr[AW-1:0]] <= mem_store_data;
      if (mem_rmem != 5'd0) rd_q <= ram[mem_addr[AW-1:0]];
    end
  end
  assign mem_load_data = rd_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model's expectations.
  always @(negedge clk) begin
    if (chk_en) begin
      check("req_ready", 32'(req_ready), 32'(exp_ready));
      check("resp_valid", 32'(resp_valid), 32'(exp_rvalid));
      if (exp_rvalid) begin
        check("resp_err", 32'(resp_err), 32'(exp_err));
        check("resp_rdata", resp_rdata, exp_rdata);
        last_rdata = resp_rdata;
        last_err   = resp_err;
      end
      check("mem_rmem", 32'(mem_rmem), 32'(exp_rmem));
      check("mem_wmem", 32'(mem_wmem), 32'(exp_wmem));
      if (exp_wmem != 4'h0) check("mem_store_data", mem_store_data, exp_sdata);
      if (exp_wmem != 4'h0 || exp_rmem != 5'd0) check("mem_addr", mem_addr, exp_addr);
      check("mem_addr_hi", 32'(mem_addr[31:AW]), 32'd0);
    end
  end

  function automatic logic model_err(input logic ld, input logic [2:0] f3, input logic [1:0] lo);
    logic legal;
    if (ld) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    else    legal = (f3 <= 3'd2);
    if (!legal) return 1'b1;
    if (f3 == 3'd2) return lo != 2'd0;
    if (f3 == 3'd1 || f3 == 3'd5) return lo[0];
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] lo, input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*lo +: 8];
    h = w[8*lo +: 16];
    case (f3)
      3'd0:    return 32'($signed(b));
      3'd1:    return 32'($signed(h));
      3'd4:    return {24'd0, b};
      3'd5:    return {16'd0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [4:0] model_rmem(input logic [2:0] f3);
    case (f3)
      3'd0:    return 5'b00001;
      3'd1:    return 5'b00010;
      3'd2:    return 5'b00100;
      3'd4:    return 5'b01000;
      default: return 5'b10000;
    endcase
  endfunction

  task automatic set_idle_exp();
    exp_ready  = 1'b1;
    exp_rvalid = 1'b0;
    exp_err    = 1'b0;
    exp_rdata  = 32'd0;
    exp_rmem   = 5'd0;
    exp_wmem   = 4'd0;
    exp_sdata  = 32'd0;
    exp_addr   = 32'd0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic [31:0] r;
    r          = $urandom;
    req_valid  = 1'b0;
    req_load   = r[0];
    req_store  = ~r[0];
    req_funct3 = r[3:1];
    req_addr   = $urandom;
    flush      = r[4];
    set_idle_exp();
    repeat (n) next_cycle();
    flush = 1'b0;
  endtask

  // One operation; flush_at picks the op-relative cycle where flush is raised.
  task automatic do_op(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input int flush_at);
    logic        err;
    int          idx, lat;
    logic [1:0]  lo;
    logic [31:0] w, ld_val;
    idx    = int'(addr[AW+1:2]);
    lo     = addr[1:0];
    err    = model_err(ld, f3, lo);
    lat    = (err || (!ld && f3 == 3'd2)) ? 1 : 2;
    ld_val = model_load(gold[idx], lo, f3);
    req_valid = 1'b1; req_load = ld; req_store = ~ld;
    req_funct3 = f3; req_addr = addr; req_wdata = wd;
    flush = (flush_at == 0);
    set_idle_exp();
    exp_addr = 32'(idx);
    if (flush_at != 0 && !err) begin
      if (ld) exp_rmem = model_rmem(f3);
      else if (f3 == 3'd2) begin
        exp_wmem = 4'hF; exp_sdata = wd; gold[idx] = wd;
      end else exp_rmem = 5'b00100;
    end
    next_cycle();
    req_valid = 1'b0;
    if (flush_at == 0) begin
      flush = 1'b0;
      return;
    end
    flush = (flush_at == 1);
    set_idle_exp();
    exp_ready = 1'b0;
    exp_addr  = 32'(idx);
    if (lat == 1) begin
      exp_rvalid = !flush; exp_err = err;
    end else if (!ld) begin
      w = gold[idx];
      if (f3 == 3'd0) w[8*lo +: 8] = wd[7:0];
      else            w[8*lo +: 16] = wd[15:0];
      exp_wmem = 4'hF; exp_sdata = w; gold[idx] = w;
    end
    next_cycle();
    if (lat == 1 || flush_at == 1) begin
      flush = 1'b0;
      return;
    end
    flush = (flush_at == 2);
    set_idle_exp();
    exp_ready  = 1'b0;
    exp_rvalid = !flush;
    exp_rdata  = ld ? ld_val : 32'd0;
    next_cycle();
    flush = 1'b0;
  endtask

  initial begin
    logic        ld;
    logic [2:0]  f3;
    logic [31:0] r, addr;
    int          k, fa;
    rst = 1'b1; ram_init = 1'b1; chk_en = 1'b0; flush = 1'b0;
    req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
    req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    last_rdata = 32'd0; last_err = 1'b0;
    set_idle_exp();
    for (int i = 0; i < WORDS; i++) gold[i] = init_val(i);
    next_cycle();
    next_cycle();
    ram_init = 1'b0;
    chk_en   = 1'b1;
    req_valid = 1'b1; req_load = 1'b1; req_addr = 32'h40;
    @(negedge clk);
    check("reset_rdata", resp_rdata, 32'd0);
    check("reset_err", 32'(resp_err), 32'd0);
    next_cycle();
    rst = 1'b0;
    idle(1);

    // Directed cases on word 0x10 = 0x8899AABB.
    do_op(1'b1, 3'd0, 32'h41, 32'd0, 9); check("lit_lb41", last_rdata, 32'hFFFF_FFAA);
    do_op(1'b1, 3'd4, 32'h41, 32'd0, 9); check("lit_lbu41", last_rdata, 32'h0000_00AA);
    do_op(1'b1, 3'd1, 32'h42, 32'd0, 9); check("lit_lh42", last_rdata, 32'hFFFF_8899);
    do_op(1'b1, 3'd5, 32'h42, 32'd0, 9); check("lit_lhu42", last_rdata, 32'h0000_8899);
    do_op(1'b1, 3'd2, 32'h40, 32'd0, 9); check("lit_lw40", last_rdata, 32'h8899_AABB);
    do_op(1'b0, 3'd0, 32'h43, 32'h12, 9); check("lit_sb43", ram[16], 32'h1299_AABB);
    do_op(1'b0, 3'd1, 32'h40, 32'h3456, 9); check("lit_sh40", ram[16], 32'h1299_3456);
    last_err = 1'b0;
    do_op(1'b1, 3'd2, 32'h42, 32'd0, 9); check("lit_err_lw42", 32'(last_err), 32'd1);
    last_err = 1'b0;
    do_op(1'b0, 3'd1, 32'h41, 32'h55, 9); check("lit_err_sh41", 32'(last_err), 32'd1);
    last_err = 1'b0;
    do_op(1'b1, 3'd3, 32'h40, 32'd0, 9); check("lit_err_f3", 32'(last_err), 32'd1);
    do_op(1'b1, 3'd2, 32'h40, 32'd0, 1);
    do_op(1'b0, 3'd0, 32'h40, 32'h77, 1); check("lit_flush_rmw", ram[16], 32'h1299_3477);
    do_op(1'b1, 3'd2, 32'hFFFF_C040, 32'd0, 9); check("lit_wrap", last_rdata, 32'h1299_3477);
    idle(1);

    // Randomized traffic over a small word window with random upper bits.
    for (int n = 0; n < 300; n++) begin
      r  = $urandom;
      ld = r[0];
      f3 = r[3:1];
      if (r[5:4] != 2'b00) begin
        k  = int'($urandom % 5);
        f3 = (k < 3) ? 3'(k) : 3'(k + 1);
        if (!ld) f3 = 3'($urandom % 3);
      end
      addr = {r[31:14], 12'(16 + ($urandom % 8)), r[7:6]};
      k  = int'($urandom % 10);
      fa = (k < 3) ? k : 9;
      do_op(ld, f3, addr, $urandom, fa);
      if (($urandom % 3) == 0) idle(int'($urandom % 3) + 1);
    end
    idle(2);
    for (int i = 16; i < 24; i++) check("ram_vs_gold", ram[i], gold[i]);

    // Reset in RMW_MERGE: no write, outputs quiet, next request accepted.
    do_op(1'b1, 3'd2, 32'h44, 32'd0, 9);
    req_valid = 1'b1; req_load = 1'b0; req_store = 1'b1;
    req_funct3 = 3'd0; req_addr = 32'h45; req_wdata = 32'hAB;
    set_idle_exp();
    exp_rmem = 5'b00100; exp_addr = 32'd17;
    next_cycle();
    req_valid = 1'b0;
    rst = 1'b1;
    set_idle_exp();
    @(negedge clk);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    next_cycle();
    rst = 1'b0;
    idle(1);
    check("rst_no_write", ram[17], gold[17]);
    do_op(1'b1, 3'd2, 32'h44, 32'd0, 9);
    check("rst_next_load", last_rdata, gold[17]);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
